// File: rtl/voice_mixer_dac.sv
`default_nettype none
// ============================================================================
// Module  : voice_mixer_dac
// Brief   : Sums NUM_VOICES signed voice samples once per output period,
//           applies gain and saturation, and drives an offset-binary DAC word
//           with a clip flag, a sticky overrun flag and a peak-hold level meter.
// Revision: 1.0 - initial release
// ============================================================================
module voice_mixer_dac #(
    parameter int NUM_VOICES = 8,
    parameter int SAMPLE_W   = 16,
    parameter int DAC_W      = 16,
    parameter int CLK_DIV    = 2048,
    parameter int GAIN_SHIFT = 3,
    parameter int LED_W      = 8,
    parameter int PEAK_HOLD  = 4096,
    localparam int SEL_W     = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                mute,
    output logic [SEL_W-1:0]    voice_sel,
    input  logic [SAMPLE_W-1:0] voice_sample,
    output logic [DAC_W-1:0]    dac_out,
    output logic                sample_strobe,
    output logic [LED_W-1:0]    leds,
    output logic                clip,
    output logic                overrun
);

    localparam int c_acc_w  = SAMPLE_W + $clog2(NUM_VOICES) + 1;
    localparam int c_cnt_w  = $clog2(CLK_DIV);
    localparam int c_hold_w = $clog2(PEAK_HOLD + 1);
    localparam int c_mag_w  = DAC_W - 1;

    localparam logic signed [c_acc_w-1:0] c_lim_hi  = c_acc_w'(2 ** (DAC_W - 1) - 1);
    localparam logic signed [c_acc_w-1:0] c_lim_lo  = c_acc_w'(-(2 ** (DAC_W - 1)));
    localparam logic signed [DAC_W-1:0]   c_sat_max = {1'b0, {(DAC_W-1){1'b1}}};
    localparam logic signed [DAC_W-1:0]   c_sat_min = {1'b1, {(DAC_W-1){1'b0}}};
    localparam logic [DAC_W-1:0]          c_mid     = {1'b1, {(DAC_W-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_OUTPUT = 2'd2
    } state_t;

    state_t                     r_state;
    state_t                     w_state_next;
    logic [c_cnt_w-1:0]         r_tick_cnt;
    logic                       w_tick;
    logic                       w_last;
    logic [SEL_W-1:0]           r_voice_sel;
    logic signed [c_acc_w-1:0]  r_acc;
    logic signed [c_acc_w-1:0]  w_sample_ext;
    logic signed [c_acc_w-1:0]  w_shifted;
    logic                       w_over;
    logic                       w_under;
    logic signed [DAC_W-1:0]    w_sat;
    logic [DAC_W-1:0]           w_dac_word;
    logic                       w_clip_next;
    logic [c_mag_w-1:0]         w_mag;
    logic [DAC_W-1:0]           r_dac_out;
    logic                       r_strobe;
    logic                       r_clip;
    logic                       r_overrun;
    logic [c_mag_w-1:0]         r_peak;
    logic [c_hold_w-1:0]        r_hold;
    logic [LED_W-1:0]           w_leds;
    logic [LED_W-1:0]           r_leds;

    // Free-running sample-rate divider; it never waits on the mixer.
    assign w_tick = (r_tick_cnt == c_cnt_w'(CLK_DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    assign w_last = (r_voice_sel == SEL_W'(NUM_VOICES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_tick) w_state_next = ST_ACCUM;
            ST_ACCUM:  if (w_last) w_state_next = ST_OUTPUT;
            ST_OUTPUT: w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    assign w_sample_ext = {{(c_acc_w-SAMPLE_W){voice_sample[SAMPLE_W-1]}}, voice_sample};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc       <= '0;
            r_voice_sel <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_tick) begin
                        r_acc       <= '0;
                        r_voice_sel <= '0;
                    end
                end
                ST_ACCUM: begin
                    r_acc       <= r_acc + w_sample_ext;
                    r_voice_sel <= w_last ? '0 : r_voice_sel + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign w_shifted = r_acc >>> GAIN_SHIFT;
    assign w_over    = (w_shifted > c_lim_hi);
    assign w_under   = (w_shifted < c_lim_lo);

    always_comb begin
        w_sat = w_shifted[DAC_W-1:0];
        if (w_over) begin
            w_sat = c_sat_max;
        end else if (w_under) begin
            w_sat = c_sat_min;
        end
    end

    assign w_dac_word  = mute ? c_mid : {~w_sat[DAC_W-1], w_sat[DAC_W-2:0]};
    assign w_clip_next = (w_over | w_under) & ~mute;

    // Negative full scale has no positive twin, so it folds onto the maximum.
    always_comb begin
        w_mag = w_sat[DAC_W-2:0];
        if (mute) begin
            w_mag = '0;
        end else if (w_sat[DAC_W-1]) begin
            w_mag = (w_sat == c_sat_min) ? {c_mag_w{1'b1}} : (~w_sat[DAC_W-2:0] + 1'b1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dac_out <= c_mid;
            r_strobe  <= 1'b0;
            r_clip    <= 1'b0;
            r_peak    <= '0;
            r_hold    <= '0;
        end else begin
            r_strobe <= 1'b0;
            if (r_state == ST_OUTPUT) begin
                r_dac_out <= w_dac_word;
                r_strobe  <= 1'b1;
                r_clip    <= w_clip_next;
                if (w_mag > r_peak) begin
                    r_peak <= w_mag;
                    r_hold <= '0;
                end else if (r_hold < c_hold_w'(PEAK_HOLD - 1)) begin
                    r_hold <= r_hold + 1'b1;
                end else begin
                    r_peak <= r_peak >> 1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overrun <= 1'b0;
        end else if (w_tick && (r_state != ST_IDLE)) begin
            r_overrun <= 1'b1;
        end
    end

    // Each LED doubles the threshold of the one below it.
    for (genvar gi = 0; gi < LED_W; gi++) begin : g_led
        assign w_leds[gi] = (r_peak >= (c_mag_w'(1) << (DAC_W - 1 - LED_W + gi)));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_leds <= '0;
        end else begin
            r_leds <= w_leds;
        end
    end

    assign voice_sel     = r_voice_sel;
    assign dac_out       = r_dac_out;
    assign sample_strobe = r_strobe;
    assign clip          = r_clip;
    assign overrun       = r_overrun;
    assign leds          = r_leds;

endmodule
`default_nettype wire

// File: tb/tb_voice_mixer_dac.sv
`default_nettype none
// ============================================================================
// Module  : tb_voice_mixer_dac
// Brief   : Scoreboard bench for voice_mixer_dac: two mixers (gain 3 / gain 0)
//           fed random voices against an arithmetic model, plus an overrun rig.
// Revision: 1.0 - initial release
// ============================================================================
module tb_voice_mixer_dac;

    localparam int NV   = 8;
    localparam int DW   = 16;
    localparam int LW   = 8;
    localparam int DIV  = NV + 3;
    localparam int FS   = 2 ** (DW - 1);
    localparam int NV_C = 4;

    typedef struct {
        logic [DW-1:0] dac;
        logic          clip;
        logic [LW-1:0] leds;
    } exp_t;

    logic               clk  = 1'b0;
    logic [2:0]         rst  = 3'b111;
    logic [1:0]         mute = 2'b00;
    logic [15:0]        voices [2][NV];
    logic [1:0][2:0]    sel;
    logic [1:0][15:0]   vs;
    logic [1:0][DW-1:0] dac;
    logic [1:0]         strobe;
    logic [1:0]         clip;
    logic [1:0]         ovr;
    logic [1:0][LW-1:0] leds;
    logic [1:0]         ov_sel;
    logic [DW-1:0]      ov_dac;
    logic               ov_strobe;
    logic               ov_clip;
    logic               ov_ovr;
    logic [LW-1:0]      ov_leds;

    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    exp_t q0[$];
    exp_t q1[$];
    int   peak [2];
    int   hold [2];

    always #5 clk = ~clk;

    assign vs[0] = voices[0][sel[0]];
    assign vs[1] = voices[1][sel[1]];

    voice_mixer_dac #(.NUM_VOICES(NV), .CLK_DIV(DIV), .GAIN_SHIFT(3), .PEAK_HOLD(2)) u_dut_a (
        .clk(clk), .reset(rst[0]), .mute(mute[0]), .voice_sel(sel[0]), .voice_sample(vs[0]),
        .dac_out(dac[0]), .sample_strobe(strobe[0]), .leds(leds[0]), .clip(clip[0]), .overrun(ovr[0]));

    voice_mixer_dac #(.NUM_VOICES(NV), .CLK_DIV(DIV), .GAIN_SHIFT(0), .PEAK_HOLD(4096)) u_dut_b (
        .clk(clk), .reset(rst[1]), .mute(mute[1]), .voice_sel(sel[1]), .voice_sample(vs[1]),
        .dac_out(dac[1]), .sample_strobe(strobe[1]), .leds(leds[1]), .clip(clip[1]), .overrun(ovr[1]));

    // Divider shorter than the accumulation, so a tick lands mid-ACCUM.
    voice_mixer_dac #(.NUM_VOICES(NV_C), .CLK_DIV(NV_C)) u_dut_c (
        .clk(clk), .reset(rst[2]), .mute(1'b0), .voice_sel(ov_sel), .voice_sample(16'h0000),
        .dac_out(ov_dac), .sample_strobe(ov_strobe), .leds(ov_leds), .clip(ov_clip), .overrun(ov_ovr));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input int k, input logic m);
        exp_t   e;
        longint sum;
        longint sh;
        longint sat;
        int     mag;
        int     ph;
        ph  = (k == 0) ? 2 : 4096;
        sum = 0;
        for (int i = 0; i < NV; i++) sum += longint'($signed(voices[k][i]));
        sh     = (k == 0) ? (sum >>> 3) : sum;
        sat    = sh;
        e.clip = 1'b0;
        if (sh > FS - 1) begin
            sat = FS - 1; e.clip = 1'b1;
        end else if (sh < -FS) begin
            sat = -FS; e.clip = 1'b1;
        end
        if (m) begin
            e.dac = 16'h8000; e.clip = 1'b0; mag = 0;
        end else begin
            e.dac = 16'(sat + FS);
            mag = (sat < 0) ? int'(-sat) : int'(sat);
            if (mag > FS - 1) mag = FS - 1;
        end
        if (mag > peak[k]) begin
            peak[k] = mag; hold[k] = 0;
        end else if (hold[k] < ph - 1) begin
            hold[k]++;
        end else begin
            peak[k] = peak[k] / 2;
        end
        for (int i = 0; i < LW; i++) e.leds[i] = (peak[k] >= (1 << (DW - 1 - LW + i)));
        return e;
    endfunction

    function automatic void push(input int k, input exp_t e);
        if (k == 0) q0.push_back(e);
        else        q1.push_back(e);
    endfunction

    // Monitor: pops one expectation per strobe, checks leds one clock later.
    int            last_s    [2] = '{-1, -1};
    int            sel1      [2] = '{-1, -1};
    bit            led_pend  [2];
    logic [LW-1:0] pend_leds [2];
    logic [LW-1:0] prev_leds [2];
    exp_t          mon_e;
    int            qs;

    always @(posedge clk) begin
        #1;
        cyc++;
        for (int k = 0; k < 2; k++) begin
            if (rst[k]) begin
                last_s[k] = -1; sel1[k] = -1; led_pend[k] = 1'b0; prev_leds[k] = '0;
            end else begin
                if (led_pend[k]) begin
                    chk($sformatf("leds[%0d]", k), 32'(leds[k]), 32'(pend_leds[k]));
                    prev_leds[k] = pend_leds[k];
                    led_pend[k]  = 1'b0;
                end
                if (sel[k] == 3'd1) sel1[k] = cyc;
                if (strobe[k]) begin
                    qs = (k == 0) ? q0.size() : q1.size();
                    n_chk++;
                    if (qs == 0) begin
                        n_fail++;
                        $display("FAIL strobe_expected[%0d]: got strobe, expected none pending", k);
                    end else begin
                        mon_e = (k == 0) ? q0.pop_front() : q1.pop_front();
                        chk($sformatf("dac_out[%0d]", k), 32'(dac[k]), 32'(mon_e.dac));
                        chk($sformatf("clip[%0d]", k), 32'(clip[k]), 32'(mon_e.clip));
                        chk($sformatf("leds_at_strobe[%0d]", k), 32'(leds[k]), 32'(prev_leds[k]));
                        chk($sformatf("overrun[%0d]", k), 32'(ovr[k]), 32'(0));
                        pend_leds[k] = mon_e.leds;
                        led_pend[k]  = 1'b1;
                    end
                    if (last_s[k] >= 0) chk($sformatf("period[%0d]", k), 32'(cyc - last_s[k]), 32'(DIV));
                    if (sel1[k] >= 0)   chk($sformatf("latency[%0d]", k), 32'(cyc - sel1[k] + 2), 32'(NV + 2));
                    last_s[k] = cyc;
                    sel1[k]   = -1;
                end
            end
        end
    end

    task automatic wait_strobe(input int k);
        int n;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!strobe[k] && n < 3 * DIV);
        chk($sformatf("strobe_seen[%0d]", k), 32'(strobe[k]), 32'(1));
    endtask

    task automatic chk_reset(input int k);
        chk($sformatf("rst_dac[%0d]", k),    32'(dac[k]),    32'(16'h8000));
        chk($sformatf("rst_strobe[%0d]", k), 32'(strobe[k]), 32'(0));
        chk($sformatf("rst_clip[%0d]", k),   32'(clip[k]),   32'(0));
        chk($sformatf("rst_ovr[%0d]", k),    32'(ovr[k]),    32'(0));
        chk($sformatf("rst_leds[%0d]", k),   32'(leds[k]),   32'(0));
        chk($sformatf("rst_sel[%0d]", k),    32'(sel[k]),    32'(0));
    endtask

    // mode 0: every voice = val; 1: independent random; 2: all at one rail.
    task automatic do_sample(input int k, input logic [15:0] val, input int mode,
                             input logic m0, input logic m1, input bit first);
        logic [15:0] rail;
        rail = ($urandom_range(0, 1) == 0) ? 16'h7FFF : 16'h8000;
        for (int i = 0; i < NV; i++) begin
            case (mode)
                0:       voices[k][i] = val;
                1:       voices[k][i] = 16'($urandom);
                default: voices[k][i] = rail;
            endcase
        end
        mute[k] = m0;
        push(k, model(k, m1));
        if (first) begin
            rst[k] = 1'b0;
        end else begin
            repeat ($urandom_range(3, 8)) @(posedge clk);
            #1;
        end
        mute[k] = m1;
        wait_strobe(k);
    endtask

    task automatic run_inst(input int k);
        int n;
        rst[k] = 1'b1; peak[k] = 0; hold[k] = 0;
        repeat (3) @(posedge clk);
        #3;
        chk_reset(k);
        if (k == 0) begin
            do_sample(0, 16'h1000, 0, 1'b0, 1'b0, 1'b1);
            do_sample(0, 16'h7FFF, 0, 1'b0, 1'b0, 1'b0);
            repeat (3) do_sample(0, 16'h0000, 0, 1'b0, 1'b0, 1'b0);
            do_sample(0, 16'h1000, 0, 1'b1, 1'b1, 1'b0);
            do_sample(0, 16'h1000, 0, 1'b1, 1'b0, 1'b0);
            do_sample(0, 16'h1000, 0, 1'b0, 1'b1, 1'b0);
        end else begin
            do_sample(1, 16'h7FFF, 0, 1'b0, 1'b0, 1'b1);
            do_sample(1, 16'h8000, 0, 1'b0, 1'b0, 1'b0);
            do_sample(1, 16'h0000, 0, 1'b0, 1'b0, 1'b0);
            do_sample(1, 16'h8000, 0, 1'b1, 1'b1, 1'b0);
        end
        repeat (25) do_sample(k, 16'h0000, int'($urandom_range(1, 2)),
                              ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), 1'b0);
        if (k == 0) begin
            n = 0;
            do begin
                @(posedge clk); #1; n++;
            end while (sel[0] != 3'd3 && n < 3 * DIV);
            chk("mid_accum_reached", 32'(sel[0]), 32'(3));
            #2;
            rst[0] = 1'b1;
            #1;
            chk_reset(0);
            repeat (4) begin
                @(posedge clk); #1;
                chk("strobe_in_reset", 32'(strobe[0]), 32'(0));
            end
            q0.delete();
            peak[0] = 0; hold[0] = 0;
            do_sample(0, 16'h1000, 0, 1'b0, 1'b0, 1'b1);
            do_sample(0, 16'h0800, 0, 1'b0, 1'b0, 1'b0);
        end
        repeat (2) @(posedge clk);
        #3;
        rst[k] = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int k = 0; k < 2; k++) for (int i = 0; i < NV; i++) voices[k][i] = 16'h0000;
        fork
            run_inst(0);
            run_inst(1);
        join
        @(posedge clk); #3;
        rst[2] = 1'b0;
        chk("ovr_after_release", 32'(ov_ovr), 32'(0));
        repeat (2) @(posedge clk);
        #1;
        chk("ovr_before_clash", 32'(ov_ovr), 32'(0));
        repeat (20) @(posedge clk);
        #1;
        chk("ovr_set", 32'(ov_ovr), 32'(1));
        repeat (20) @(posedge clk);
        #1;
        chk("ovr_sticky", 32'(ov_ovr), 32'(1));
        #2;
        rst[2] = 1'b1;
        #1;
        chk("ovr_reset", 32'(ov_ovr), 32'(0));
        chk("q0_drained", 32'(q0.size()), 32'(0));
        chk("q1_drained", 32'(q1.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/voice_mixer_dac.md
VOICE_MIXER_DAC -- requirements
Module: voice_mixer_dac

Interface
REQ-001 Parameter NUM_VOICES, default 8: number of voice samples summed per output sample, range 1..64.
REQ-002 Parameter SAMPLE_W, default 16: signed voice sample width.
REQ-003 Parameter DAC_W, default 16: DAC word width, with DAC_W <= SAMPLE_W.
REQ-004 Parameter CLK_DIV, default 2048: clocks per output sample, and SHALL satisfy CLK_DIV >= NUM_VOICES+3.
REQ-005 Parameter GAIN_SHIFT, default 3: arithmetic right shift applied to the mix sum.
REQ-006 Parameter LED_W, default 8: level meter width, with LED_W <= DAC_W-1.
REQ-007 Parameter PEAK_HOLD, default 4096: output samples a peak is held before decay starts.
REQ-008 clk  in  1  single system clock; all logic runs on rising edge.
REQ-009 reset  in  1  asynchronous, active-high reset.
REQ-010 mute  in  1  when high, the DAC output is forced to midscale.
REQ-011 voice_sel  out  clog2(NUM_VOICES) (min 1)  index of the voice sample requested.
REQ-012 voice_sample  in  SAMPLE_W  signed sample of voice voice_sel, combinationally valid in the same cycle.
REQ-013 dac_out  out  DAC_W  offset-binary DAC word, registered.
REQ-014 sample_strobe  out  1  one-cycle pulse in the cycle dac_out updates.
REQ-015 leds  out  LED_W  thermometer level meter.
REQ-016 clip  out  1  high for the sample period following a saturated output.
REQ-017 overrun  out  1  sticky flag, set when a sample tick arrives while the mixer is busy.

Function
REQ-018 The tick counter SHALL count 0..CLK_DIV-1 and wrap, asserting an internal tick when the count equals CLK_DIV-1.
REQ-019 The FSM SHALL have states IDLE, ACCUM and OUTPUT.
REQ-020 IDLE->ACCUM on tick, clearing the accumulator and voice_sel to 0.
REQ-021 In ACCUM, each cycle SHALL add sign-extended voice_sample to the accumulator (width SAMPLE_W+clog2(NUM_VOICES)+1) and increment voice_sel; after the add with voice_sel = NUM_VOICES-1, go to OUTPUT with voice_sel = 0.
REQ-022 In OUTPUT, acc >>> GAIN_SHIFT SHALL be saturated to the signed DAC_W range [-2^(DAC_W-1), 2^(DAC_W-1)-1].
REQ-023 dac_out SHALL be the saturated value with its MSB inverted, and SHALL be 2^(DAC_W-1) when mute is high.
REQ-024 dac_out and sample_strobe SHALL register on the OUTPUT->IDLE transition, giving a latency of NUM_VOICES+2 clocks from tick to strobe.
REQ-025 clip SHALL be set with the strobe if saturation occurred, and SHALL otherwise clear on the next strobe; muted samples are never clipped.
REQ-026 A tick occurring in ACCUM or OUTPUT SHALL be ignored and SHALL set overrun, which clears only on reset.
REQ-027 Magnitude SHALL be the absolute value of the saturated sample, with -2^(DAC_W-1) mapped to 2^(DAC_W-1)-1; when muted, magnitude is 0.
REQ-028 Peak update at each strobe:
  - magnitude > peak: peak = magnitude, hold counter = 0.
  - else, hold counter < PEAK_HOLD-1: hold counter increments.
  - else: peak = peak >> 1.
REQ-029 leds[i] SHALL be 1 iff peak >= 2^(DAC_W-1-LED_W+i), for i = 0..LED_W-1.
REQ-030 leds SHALL be registered and update one clock after the strobe.
REQ-031 mute changing mid-ACCUM SHALL affect only the value registered at OUTPUT and SHALL NOT disturb the accumulation.

Reset
REQ-032 While reset is high, the following SHALL hold asynchronously:
  - dac_out = 2^(DAC_W-1) (0x8000 at default).
  - sample_strobe, clip, overrun and leds = 0.
  - voice_sel = 0, state = IDLE.
  - tick counter, accumulator, peak and hold counter = 0.
REQ-033 Reset asserted mid-ACCUM SHALL abandon the sum.
REQ-034 After release, the first tick SHALL occur CLK_DIV clocks later.

Verification (defaults unless stated)
REQ-035 All voices = 0x1000 -> sum 0x8000, >>>3 = 0x1000 -> dac_out 0x9000; strobe NUM_VOICES+2 = 10 clocks after tick; leds = 0x3F; clip = 0.
REQ-036 All voices = 0x7FFF -> sum 0x3FFF8, >>>3 = 0x7FFF -> dac_out 0xFFFF, clip = 0; with GAIN_SHIFT = 0, dac_out 0xFFFF and clip = 1.
REQ-037 All voices = 0x8000 (negative full scale), GAIN_SHIFT = 0 -> dac_out 0x0000, clip = 1, leds = 0xFF.
REQ-038 mute = 1 with voices = 0x1000 -> dac_out 0x8000, clip = 0, peak not raised.
REQ-039 Peak decay: one sample at leds = 0xFF followed by zero input, with PEAK_HOLD = 2 -> leds stay 0xFF for 2 strobes, then lose one LED per strobe.
REQ-040 CLK_DIV = NUM_VOICES+3 runs without overrun; forcing a tick during ACCUM sets overrun = 1; asserting reset mid-ACCUM gives dac_out = 0x8000 immediately, with no strobe.
